npu_conv_window_engine: RTL and testbench

Parametrised successor to the single-pixel host-triggered convolution datapath. It holds a K_H×K_W sliding window fed one input column per bus write and computes one full-window dot product per accepted column once the window is full. The dot product is pipelined, optionally ReLU-clamped, saturated to ACC_W, and queued in a result FIFO that the host pops over the same 32-bit memory-mapped port. The block replaces per-pixel trigger/minus sequencing with autonomous row streaming, and adds signed/unsigned input mode, backpressure and error flags.

---
 rtl/npu_pkg.sv | 32 +++
 rtl/npu_res_fifo.sv | 57 +++++
 rtl/npu_conv_window_engine.sv | 255 +++++++++++++++++++++++++
 tb/tb_npu_conv_window_engine.sv | 295 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/npu_pkg.sv
// Shared definitions for the convolution window engine: bus address map,
// control/status bit positions, row FSM states and datapath width helper.
package npu_pkg;

  localparam logic [2:0] SEL_COL    = 3'd1;
  localparam logic [2:0] SEL_WGT    = 3'd2;
  localparam logic [2:0] SEL_CTL    = 3'd4;
  localparam logic [2:0] SEL_STATUS = 3'd5;
  localparam logic [2:0] SEL_POP    = 3'd6;
  localparam logic [2:0] SEL_COUNT  = 3'd7;

  localparam int CTL_ROW_START = 0;
  localparam int CTL_RELU      = 1;
  localparam int CTL_SIGNED    = 2;
  localparam int CTL_CLEAR     = 3;

  localparam int STAT_NONEMPTY = 0;
  localparam int STAT_IN_READY = 1;
  localparam int STAT_UNF      = 2;
  localparam int STAT_OVF      = 3;

  typedef enum logic [0:0] {
    S_FILL = 1'b0,
    S_RUN  = 1'b1
  } row_state_e;

  // Width that holds the exact sum of all window products without overflow.
  function automatic int sum_width(input int dw, input int ww, input int taps);
    return dw + ww + 1 + $clog2(taps);
  endfunction

endpackage

// File: rtl/npu_res_fifo.sv
// Synchronous result FIFO with first-word fall-through read data.
// Push and pop may occur on the same edge; flush empties it in one cycle.
module npu_res_fifo #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 24
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     i_flush,
  input  logic                     i_push,
  input  logic [WIDTH-1:0]         i_data,
  input  logic                     i_pop,
  output logic [WIDTH-1:0]         o_data,
  output logic [$clog2(DEPTH):0]   o_count,
  output logic                     o_full,
  output logic                     o_empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [AW:0]      r_count;
  logic             w_do_push;
  logic             w_do_pop;

  assign o_empty   = (r_count == '0);
  assign o_full    = (r_count == (AW+1)'(DEPTH));
  assign w_do_pop  = i_pop & ~o_empty;
  // A full FIFO can still take a push when the same edge frees a slot.
  assign w_do_push = i_push & (~o_full | w_do_pop);

  always_ff @(posedge clk) begin
    if (rst || i_flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + (AW+1)'(1);
        2'b01:   r_count <= r_count - (AW+1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (w_do_push) r_mem[r_wr_ptr] <= i_data;
  end

  assign o_data  = r_mem[r_rd_ptr];
  assign o_count = r_count;

endmodule

// File: rtl/npu_conv_window_engine.sv
// Sliding K_H x K_W convolution window fed one column per bus write; each
// accepted column on a full window yields one saturated dot product in a FIFO.
module npu_conv_window_engine
  import npu_pkg::*;
#(
  parameter int K_H        = 3,
  parameter int K_W        = 3,
  parameter int DW         = 8,
  parameter int WW         = 8,
  parameter int ACC_W      = 24,
  parameter int FIFO_DEPTH = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ena,
  input  logic        wea,
  input  logic [15:0] addra,
  input  logic [31:0] dina,
  output logic [31:0] douta,
  output row_state_e  o_dbg_state
);

  localparam int N_TAPS = K_H * K_W;
  localparam int PROD_W = DW + 1 + WW;
  localparam int SUM_W  = sum_width(DW, WW, N_TAPS);
  localparam int EXT_W  = ((SUM_W > ACC_W) ? SUM_W : ACC_W) + 1;
  localparam int CNT_W  = $clog2(FIFO_DEPTH) + 1;
  localparam int COL_W  = $clog2(K_W + 1);

  localparam logic [ACC_W-1:0]        RES_MAX = {1'b0, {(ACC_W-1){1'b1}}};
  localparam logic [ACC_W-1:0]        RES_MIN = {1'b1, {(ACC_W-1){1'b0}}};
  localparam logic signed [EXT_W-1:0] SAT_MAX = EXT_W'($signed(RES_MAX));
  localparam logic signed [EXT_W-1:0] SAT_MIN = EXT_W'($signed(RES_MIN));

  // Bus decode
  logic [2:0] w_sel;
  logic [7:0] w_idx;
  logic       w_wr, w_rd;
  logic       w_col_wr, w_wgt_wr, w_ctl_wr;
  logic       w_clear, w_row_start;
  logic       w_col_acc, w_pop_rd, w_pop;
  logic       w_in_ready;

  assign w_sel       = addra[14:12];
  assign w_idx       = addra[7:0];
  assign w_wr        = ena & wea;
  assign w_rd        = ena & ~wea;
  assign w_col_wr    = w_wr & (w_sel == SEL_COL);
  assign w_wgt_wr    = w_wr & (w_sel == SEL_WGT);
  assign w_ctl_wr    = w_wr & (w_sel == SEL_CTL);
  assign w_clear     = w_ctl_wr & dina[CTL_CLEAR];
  assign w_row_start = w_ctl_wr & dina[CTL_ROW_START] & ~dina[CTL_CLEAR];
  assign w_col_acc   = w_col_wr & w_in_ready;
  assign w_pop_rd    = w_rd & (w_sel == SEL_POP);

  // FIFO and occupancy; in-flight results reserve their FIFO slot up front
  logic [ACC_W-1:0] w_res;
  logic [ACC_W-1:0] w_fifo_data;
  logic [CNT_W-1:0] w_fifo_count;
  logic             w_fifo_full, w_fifo_empty;
  logic             r_v0, r_v1;
  logic [1:0]       w_inflight;
  logic [CNT_W:0]   w_occupancy;

  assign w_inflight  = {1'b0, r_v0} + {1'b0, r_v1};
  assign w_occupancy = {1'b0, w_fifo_count} + (CNT_W+1)'(w_inflight);
  assign w_in_ready  = (w_occupancy < (CNT_W+1)'(FIFO_DEPTH));
  assign w_pop       = w_pop_rd & ~w_fifo_empty;

  npu_res_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (ACC_W)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_flush (w_clear),
    .i_push  (r_v1),
    .i_data  (w_res),
    .i_pop   (w_pop),
    .o_data  (w_fifo_data),
    .o_count (w_fifo_count),
    .o_full  (w_fifo_full),
    .o_empty (w_fifo_empty)
  );

  // Row FSM
  row_state_e       r_state, w_state_next;
  logic [COL_W-1:0] r_col_cnt;
  logic             w_fill_last;
  logic             w_issue, w_cnt_inc;

  assign w_fill_last = (r_col_cnt == COL_W'(K_W - 1));

  always_ff @(posedge clk) begin
    if (rst || w_clear) r_state <= S_FILL;
    else                r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    if (w_row_start)
      w_state_next = S_FILL;
    else if (w_col_acc && (r_state == S_FILL) && w_fill_last)
      w_state_next = S_RUN;
  end

  always_comb begin
    w_issue   = 1'b0;
    w_cnt_inc = 1'b0;
    if (w_col_acc) begin
      case (r_state)
        S_FILL: begin
          if (w_fill_last) w_issue   = 1'b1;
          else             w_cnt_inc = 1'b1;
        end
        S_RUN:   w_issue = 1'b1;
        default: w_issue = 1'b0;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst || w_clear || w_row_start) r_col_cnt <= '0;
    else if (w_cnt_inc)                r_col_cnt <= r_col_cnt + COL_W'(1);
  end

  assign o_dbg_state = r_state;

  // Window: column 0 is the oldest, column K_W-1 the newest
  logic [DW-1:0] r_win [K_H][K_W];

  always_ff @(posedge clk) begin
    if (w_col_acc) begin
      for (int r = 0; r < K_H; r++) begin
        for (int c = 0; c < K_W - 1; c++) r_win[r][c] <= r_win[r][c+1];
        r_win[r][K_W-1] <= dina[r*DW +: DW];
      end
    end
  end

  // Weights and configuration
  logic signed [WW-1:0] r_wgt [N_TAPS];
  logic                 r_relu_en, r_signed_in;

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < N_TAPS; i++) r_wgt[i] <= '0;
    end else if (w_wgt_wr) begin
      for (int i = 0; i < N_TAPS; i++)
        if (w_idx == 8'(i)) r_wgt[i] <= dina[WW-1:0];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_relu_en   <= 1'b1;
      r_signed_in <= 1'b0;
    end else if (w_ctl_wr) begin
      r_relu_en   <= dina[CTL_RELU];
      r_signed_in <= dina[CTL_SIGNED];
    end
  end

  // Stage 1: per-tap products
  logic signed [DW:0]       w_px_ext [N_TAPS];
  logic signed [PROD_W-1:0] w_prod   [N_TAPS];
  logic signed [PROD_W-1:0] r_prod   [N_TAPS];
  logic                     r_relu_s1;

  always_comb begin
    for (int r = 0; r < K_H; r++) begin
      for (int c = 0; c < K_W; c++) begin
        w_px_ext[r*K_W+c] = {r_signed_in & r_win[r][c][DW-1], r_win[r][c]};
      end
    end
    for (int i = 0; i < N_TAPS; i++)
      w_prod[i] = PROD_W'(w_px_ext[i]) * PROD_W'(r_wgt[i]);
  end

  always_ff @(posedge clk) begin
    if (rst || w_clear) begin
      r_v0 <= 1'b0;
      r_v1 <= 1'b0;
    end else begin
      r_v0 <= w_issue;
      r_v1 <= r_v0;
    end
  end

  // ReLU is captured with the products so a later config write cannot leak in
  always_ff @(posedge clk) begin
    if (r_v0) begin
      for (int i = 0; i < N_TAPS; i++) r_prod[i] <= w_prod[i];
      r_relu_s1 <= r_relu_en;
    end
  end

  // Stage 2: exact sum, ReLU, saturate
  logic signed [SUM_W-1:0] w_sum, w_sum_relu;
  logic signed [EXT_W-1:0] w_sum_ext;

  always_comb begin
    w_sum = '0;
    for (int i = 0; i < N_TAPS; i++) w_sum = w_sum + SUM_W'(r_prod[i]);
    w_sum_relu = (r_relu_s1 && w_sum[SUM_W-1]) ? '0 : w_sum;
    w_sum_ext  = EXT_W'(w_sum_relu);
    if (w_sum_ext > SAT_MAX)      w_res = RES_MAX;
    else if (w_sum_ext < SAT_MIN) w_res = RES_MIN;
    else                          w_res = w_sum_ext[ACC_W-1:0];
  end

  // Sticky flags
  logic r_ovf, r_unf;

  always_ff @(posedge clk) begin
    if (rst || w_clear) begin
      r_ovf <= 1'b0;
      r_unf <= 1'b0;
    end else begin
      if (w_col_wr && !w_in_ready)  r_ovf <= 1'b1;
      if (w_pop_rd && w_fifo_empty) r_unf <= 1'b1;
    end
  end

  // Read data
  logic [31:0] w_status;

  always_comb begin
    w_status                = '0;
    w_status[STAT_NONEMPTY] = ~w_fifo_empty;
    w_status[STAT_IN_READY] = w_in_ready;
    w_status[STAT_UNF]      = r_unf;
    w_status[STAT_OVF]      = r_ovf;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      douta <= '0;
    end else if (w_rd) begin
      case (w_sel)
        SEL_STATUS: douta <= w_status;
        SEL_POP: begin
          if (w_fifo_empty) douta <= '0;
          else              douta <= 32'($signed(w_fifo_data));
        end
        SEL_COUNT: douta <= 32'(w_fifo_count);
        default:   douta <= '0;
      endcase
    end
  end

  logic w_unused_bits;
  assign w_unused_bits = ^{addra[15], addra[11:8], dina, w_fifo_full};

endmodule

// File: tb/tb_npu_conv_window_engine.sv
// Bench for npu_conv_window_engine: directed scenarios followed by random
// traffic, checked against an arithmetic model of the window and result queue.
module tb_npu_conv_window_engine;

  logic        clk = 1'b0;
  logic        rst;
  logic        ena;
  logic        wea;
  logic [15:0] addra;
  logic [31:0] dina;
  logic [31:0] douta;
  logic [31:0] douta16;
  npu_pkg::row_state_e dbg_state;
  npu_pkg::row_state_e dbg_state16;

  always #5 clk = ~clk;

  npu_conv_window_engine u_dut (
    .clk         (clk),
    .rst         (rst),
    .ena         (ena),
    .wea         (wea),
    .addra       (addra),
    .dina        (dina),
    .douta       (douta),
    .o_dbg_state (dbg_state)
  );

  npu_conv_window_engine #(.ACC_W(16)) u_dut16 (
    .clk         (clk),
    .rst         (rst),
    .ena         (ena),
    .wea         (wea),
    .addra       (addra),
    .dina        (dina),
    .douta       (douta16),
    .o_dbg_state (dbg_state16)
  );

  int checks = 0;
  int errors = 0;

  // Reference model: window as the last three columns, oldest first
  typedef int col_t [3];
  col_t        m_win[$];
  int          m_w[9];
  bit          m_relu, m_signed, m_ovf, m_unf;
  logic [31:0] exp_q[$];
  logic [31:0] exp16_q[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic bus_write(input logic [2:0] sel, input logic [7:0] idx, input logic [31:0] data);
    ena   = 1'b1;
    wea   = 1'b1;
    addra = {1'b0, sel, 4'h0, idx};
    dina  = data;
    @(negedge clk);
    ena = 1'b0;
    wea = 1'b0;
  endtask

  task automatic bus_read(input logic [2:0] sel, output logic [31:0] d, output logic [31:0] d16);
    ena   = 1'b1;
    wea   = 1'b0;
    addra = {1'b0, sel, 4'h0, 8'h00};
    @(negedge clk);
    d   = douta;
    d16 = douta16;
    ena = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  function automatic logic [31:0] ref_res(input int acc_w);
    longint s, p, lim;
    s = 0;
    for (int r = 0; r < 3; r++) begin
      for (int c = 0; c < 3; c++) begin
        p = m_win[c][r];
        if (m_signed && p > 127) p = p - 256;
        s += p * longint'(m_w[r*3+c]);
      end
    end
    if (m_relu && s < 0) s = 0;
    lim = longint'(1) << (acc_w - 1);
    if (s > lim - 1) s = lim - 1;
    if (s < -lim)    s = -lim;
    return s[31:0];
  endfunction

  task automatic col(input int a, input int b, input int c);
    col_t v;
    v = '{a, b, c};
    if (exp_q.size() >= 16) begin
      m_ovf = 1'b1;
    end else begin
      m_win.push_back(v);
      if (m_win.size() > 3) void'(m_win.pop_front());
      if (m_win.size() == 3) begin
        exp_q.push_back(ref_res(24));
        exp16_q.push_back(ref_res(16));
      end
    end
    bus_write(3'd1, 8'd0, {8'($urandom), 8'(c), 8'(b), 8'(a)});
  endtask

  task automatic rand_col();
    col($urandom_range(0, 255), $urandom_range(0, 255), $urandom_range(0, 255));
  endtask

  task automatic wgt(input int idx, input int val);
    if (idx < 9) m_w[idx] = val;
    bus_write(3'd2, 8'(idx), {24'($urandom), 8'(val)});
  endtask

  task automatic ctl(input bit rs, input bit relu, input bit sgn, input bit clr);
    m_relu   = relu;
    m_signed = sgn;
    if (clr) begin
      exp_q.delete();
      exp16_q.delete();
      m_win.delete();
      m_ovf = 1'b0;
      m_unf = 1'b0;
    end else if (rs) begin
      m_win.delete();
    end
    bus_write(3'd4, 8'd0, {28'($urandom), clr, sgn, relu, rs});
  endtask

  task automatic pop_chk(input string tag, output logic [31:0] d);
    logic [31:0] d16, e, e16;
    bus_read(3'd6, d, d16);
    if (exp_q.size() == 0) begin
      e     = '0;
      e16   = '0;
      m_unf = 1'b1;
    end else begin
      e   = exp_q.pop_front();
      e16 = exp16_q.pop_front();
    end
    chk(tag, d, e);
    chk({tag, "_acc16"}, d16, e16);
  endtask

  task automatic status_chk(input string tag);
    logic [31:0] d, d16, e;
    logic        rdy, nonempty;
    rdy      = (exp_q.size() < 16);
    nonempty = (exp_q.size() > 0);
    e        = {28'd0, m_ovf, m_unf, rdy, nonempty};
    bus_read(3'd5, d, d16);
    chk(tag, d, e);
    chk({tag, "_acc16"}, d16, e);
  endtask

  task automatic count_chk(input string tag);
    logic [31:0] d, d16;
    bus_read(3'd7, d, d16);
    chk(tag, d, 32'(exp_q.size()));
  endtask

  initial begin
    logic [31:0] d, d16;
    rst   = 1'b1;
    ena   = 1'b0;
    wea   = 1'b0;
    addra = '0;
    dina  = '0;
    m_relu   = 1'b1;
    m_signed = 1'b0;
    m_ovf    = 1'b0;
    m_unf    = 1'b0;
    for (int i = 0; i < 9; i++) m_w[i] = 0;
    repeat (3) @(negedge clk);
    rst = 1'b0;

    // Reset state
    chk("reset_douta", douta, 32'd0);
    chk("reset_fsm", 32'(dbg_state), 32'd0);
    status_chk("reset_status");
    count_chk("reset_count");

    // All-ones weights, unsigned: latency and basic sum
    for (int i = 0; i < 9; i++) wgt(i, 1);
    col(1, 2, 3);
    col(1, 2, 3);
    col(1, 2, 3);
    bus_read(3'd7, d, d16);
    chk("count_n1", d, 32'd0);
    bus_read(3'd7, d, d16);
    chk("count_n2", d, 32'd0);
    bus_read(3'd7, d, d16);
    chk("count_n3", d, 32'd1);
    pop_chk("pop_first", d);
    chk("pop_first_val", d, 32'd18);
    col(4, 4, 4);
    idle(3);
    pop_chk("pop_second", d);
    chk("pop_second_val", d, 32'd24);

    // Signed input, ReLU off then on
    ctl(1'b1, 1'b0, 1'b1, 1'b0);
    wgt(0, 2);
    for (int i = 1; i < 9; i++) wgt(i, 0);
    repeat (3) col(8'hFF, 0, 0);
    idle(3);
    pop_chk("pop_signed", d);
    chk("pop_signed_val", d, 32'hFFFF_FFFE);
    ctl(1'b0, 1'b1, 1'b1, 1'b0);
    col(8'hFF, 0, 0);
    idle(3);
    pop_chk("pop_relu", d);
    chk("pop_relu_val", d, 32'd0);

    // Saturation on the 16-bit instance
    ctl(1'b0, 1'b1, 1'b0, 1'b1);
    for (int i = 0; i < 9; i++) wgt(i, 127);
    repeat (3) col(255, 255, 255);
    idle(3);
    pop_chk("pop_big", d);
    chk("pop_big_val", d, 32'd291465);
    chk("fifo_head_sat16", douta16, 32'd32767);

    // Backpressure: fill the FIFO, then one column too many
    ctl(1'b0, 1'b1, 1'b0, 1'b1);
    repeat (18) rand_col();
    rand_col();
    idle(3);
    status_chk("status_full");
    count_chk("count_full");
    pop_chk("pop_full", d);
    rand_col();
    idle(3);
    count_chk("count_refill");
    for (int i = 0; i < 16; i++) pop_chk("pop_drain", d);
    pop_chk("pop_empty", d);
    chk("pop_empty_val", d, 32'd0);
    status_chk("status_unf");
    ctl(1'b0, 1'b1, 1'b0, 1'b1);
    status_chk("status_clear");
    count_chk("count_clear");
    repeat (3) rand_col();
    idle(3);
    pop_chk("pop_after_clear", d);

    // row_start discards the partial window
    ctl(1'b0, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 9; i++) wgt(i, $urandom_range(0, 255) - 128);
    rand_col();
    rand_col();
    ctl(1'b1, 1'b0, 1'b1, 1'b0);
    rand_col();
    rand_col();
    idle(3);
    count_chk("count_row_start");
    chk("fsm_fill", 32'(dbg_state), 32'd0);
    rand_col();
    chk("fsm_run", 32'(dbg_state), 32'd1);
    idle(3);
    count_chk("count_row_result");
    pop_chk("pop_row_result", d);

    // Random traffic
    for (int it = 0; it < 30; it++) begin
      repeat ($urandom_range(0, 3)) wgt($urandom_range(0, 11), $urandom_range(0, 255) - 128);
      ctl($urandom_range(0, 3) == 0, $urandom_range(0, 1), $urandom_range(0, 1),
          $urandom_range(0, 9) == 0);
      if ($urandom_range(0, 3) == 0) begin
        bus_write(3'd3, 8'($urandom), $urandom);
        bus_read(3'd0, d, d16);
        chk("read_unmapped", d, 32'd0);
      end
      repeat ($urandom_range(1, 6)) rand_col();
      if ($urandom_range(0, 1) == 1) wgt($urandom_range(0, 8), $urandom_range(0, 255) - 128);
      idle(3);
      repeat ($urandom_range(0, 6)) pop_chk("pop_rand", d);
      status_chk("status_rand");
      count_chk("count_rand");
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
